receiver_uart: RTL and testbench
================================

# receiver_uart

UART receiver that samples the board RX pin, reassembles 8N1 frames and buffers received bytes in a small show-ahead FIFO. It sits beside `emitter_uart` in `soc`, on the CPU's memory-mapped IO space: a data register pops bytes and a status register exposes valid and error flags. It is the inbound counterpart of the transmit path and shares its clock-rate and baud parameters.

## Interface
- `CLK_FREQ_HZ`, default 12000000: system clock frequency.
- `BAUD_RATE`, default 115200: line rate.
- `FIFO_DEPTH`, default 4: byte buffer depth; must be a power of 2 and at least 2.
- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  raw UART line, asynchronous to `clk`, idle high.
- `o_data`  out  8  byte at the FIFO head; holds 0 when the FIFO is empty.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  pop request; a pop happens when `o_valid && i_ready`.
- `o_frame_err`  out  1  sticky flag: a stop bit was sampled low.
- `o_overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `i_clr_err`  in  1  one-cycle pulse that clears both sticky flags.

## Operation
- Baud arithmetic:
  - `CPB = CLK_FREQ_HZ / BAUD_RATE`, integer division (104 at the defaults).
  - `HALF = CPB / 2` (52 at the defaults).
  - The counter width is `$clog2(CPB)`.
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All FSM logic uses the synchronized value `rxs`.
- FSM states:
  - **IDLE**: when `rxs == 0`, go to START and clear the counter.
  - **START**: count to `HALF-1` and then sample `rxs`.
    - 1: treat it as a glitch and return to IDLE.
    - 0: go to DATA with the counter and bit index cleared.
  - **DATA**: every `CPB` cycles, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
  - **STOP**: after `CPB` cycles, sample `rxs`.
    - 1: push the byte and go to IDLE.
    - 0: set `o_frame_err`, discard the byte and go to BREAK.
  - **BREAK**: wait until `rxs == 1`, then go to IDLE. This prevents a held-low line from retriggering continuously.
- Push when the FIFO is full:
  - If a pop occurs in the same cycle, the push is accepted and no flag is set.
  - Otherwise the byte is dropped, `o_overrun` is set, and the FIFO contents are unchanged.
- Pop when the FIFO is empty: no effect.
- Simultaneous push and pop when the FIFO is not full: count unchanged, order preserved.
- Error flags:
  - `i_clr_err` in the same cycle as a new error event: the set wins.
  - The flags do not block reception.
- The FIFO uses read and write pointers `$clog2(FIFO_DEPTH)+1` bits wide.
  - Full: the MSBs differ and the remaining bits are equal.
  - Pointers wrap naturally.

## Timing
- Reset values:
  - FSM in IDLE.
  - Synchronizer flops at 1.
  - FIFO empty: `o_valid=0`, `o_data=0`.
  - `o_frame_err=0`, `o_overrun=0`.
  - Counters and shift register at 0.
- Reset asserted mid-frame aborts immediately. The next frame after release is received normally.
- Latency:
  - The first clock edge seeing `rx=0` is cycle 0. `rxs` falls at cycle 2.
  - The stop-bit sample occurs at cycle `2 + HALF + 9*CPB`, which is 990 at the defaults.
  - `o_valid` and `o_data` update at cycle `3 + HALF + 9*CPB`, which is 991.
- Pop timing:
  - A pop takes effect at the clock edge where `o_valid && i_ready`.
  - The next head byte is presented in the following cycle.
  - There is no combinational path from `i_ready` to `o_data`.
- The error flags assert the cycle after the stop-bit sample.
- Sustained reception tolerates a baud mismatch of up to about ±2%, from mid-bit sampling.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - Constant function computing `CPB` and `HALF` from the two parameters, also usable by `emitter_uart`.
- One sub-module `sync_fifo`, parameterized by width and depth:
  - Show-ahead read, registered outputs.
  - Ports: push and data in; pop; data out; empty; full.
- The synchronizer, FSM, baud counter and flag logic stay in `receiver_uart`.

## Test plan
- **Single byte:** send 0x55 at 115200 with `i_ready=0` → `o_valid` rises at cycle 991 after the start edge, `o_data=0x55`, both error flags 0.
- **Back-to-back with pop:** send 0xA5 then 0x3C with `i_ready=0` → 0xA5 appears first. Pulse `i_ready` → 0x3C appears the next cycle. Pulse again → `o_valid=0`, `o_data=0`.
- **Overrun:** send 5 bytes 0x01..0x05 with no pops → `o_overrun=1`. Popping returns 0x01..0x04, then `o_valid=0`. Pulse `i_clr_err` → `o_overrun=0`.
- **Framing error:** send 0x7E with the stop bit low, holding low for 3 bit times → `o_frame_err=1`, nothing pushed. Release the line, then send 0x42 → 0x42 is received.
- **Glitch rejection:** drive `rx` low for 20 cycles → FSM returns to IDLE, no push, no flags. Then send 0xC3 → received correctly.
- **Reset mid-frame:** assert `rstn=0` during data bit 4 → all outputs at their reset values. Release, then send 0x99 → `o_data=0x99` at cycle 991.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud arithmetic helpers,
// used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

    // Clock cycles per bit, integer-truncated.
    function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned calc_half(input int unsigned clk_hz, input int unsigned baud);
        return calc_cpb(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered head output; head reads as 0 when empty.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wptr_q, wptr_d;
    logic [AddrW:0]   rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdata_d = '0;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        // The next head may be the byte being written this very cycle.
        if (wptr_d != rptr_d) begin
            if (do_push && (rptr_d[AddrW-1:0] == wptr_q[AddrW-1:0])) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[rptr_d[AddrW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
            if (do_push) begin
                mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/receiver_uart.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, buffers bytes in a show-ahead
// FIFO and keeps sticky framing/overrun flags.
module receiver_uart
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_clr_err
);

    localparam int unsigned Cpb  = calc_cpb(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned Half = calc_half(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CntW = $clog2(Cpb);

    localparam logic [CntW-1:0] CntLast  = CntW'(Cpb - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);

    uart_state_e     state_q, state_d;
    logic            sync1_q, rxs_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            ferr_evt_q, ferr_evt_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            fifo_empty, fifo_full;
    logic            pop;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        ferr_evt_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    state_d = rxs_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_evt_d = 1'b1;
                        state_d    = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop = !fifo_empty && i_ready;

    // Set has priority over clear so a coincident error is never lost.
    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (i_clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (ferr_evt_q) begin
            frame_err_d = 1'b1;
        end
        if (push_q && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            ferr_evt_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            ferr_evt_q  <= ferr_evt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .push_i  (push_q),
        .wdata_i (shift_q),
        .pop_i   (i_ready),
        .rdata_o (o_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign o_valid     = !fifo_empty;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_receiver_uart.sv
// Directed bench for receiver_uart at the default 12 MHz / 115200 baud (104 cycles per bit).
module tb_receiver_uart;

    localparam int Cpb = 104;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_clr_err;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    receiver_uart dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx          (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_clr_err   (i_clr_err)
    );

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; drives one frame and returns at a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_bits);
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (Cpb) @(negedge clk);
        end
        rx = stop;
        repeat (Cpb * stop_bits) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends a byte into an empty FIFO and measures cycles from the first edge seeing rx=0.
    task automatic send_and_time(input logic [7:0] d, output int l);
        int c;
        l = -1;
        c = 0;
        fork
            send_frame(d, 1'b1, 1);
            begin
                while (l < 0 && c < 1500) begin
                    @(posedge clk);
                    #1;
                    if (o_valid) l = c;
                    c++;
                end
            end
        join
    endtask

    task automatic pop_one();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic clr_err();
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] ovr_bytes [5];
        ovr_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        rx        = 1'b1;
        rstn      = 1'b0;
        i_ready   = 1'b0;
        i_clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", int'(o_valid), 0);
        check_eq("rst_data", int'(o_data), 0);
        check_eq("rst_ferr", int'(o_frame_err), 0);
        check_eq("rst_ovr", int'(o_overrun), 0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte with latency.
        send_and_time(8'h55, lat);
        check_eq("single_latency", lat, 991);
        check_eq("single_data", int'(o_data), 'h55);
        check_eq("single_ferr", int'(o_frame_err), 0);
        check_eq("single_ovr", int'(o_overrun), 0);
        pop_one();
        check_eq("single_popped", int'(o_valid), 0);

        // Back-to-back frames, then pop both.
        send_frame(8'hA5, 1'b1, 1);
        send_frame(8'h3C, 1'b1, 1);
        check_eq("b2b_first", int'(o_data), 'hA5);
        pop_one();
        check_eq("b2b_second", int'(o_data), 'h3C);
        check_eq("b2b_valid", int'(o_valid), 1);
        pop_one();
        check_eq("b2b_empty_valid", int'(o_valid), 0);
        check_eq("b2b_empty_data", int'(o_data), 0);
        pop_one();
        check_eq("pop_on_empty", int'(o_valid), 0);

        // Overrun: fifth byte dropped.
        for (int i = 0; i < 5; i++) send_frame(ovr_bytes[i], 1'b1, 1);
        check_eq("ovr_flag", int'(o_overrun), 1);
        check_eq("ovr_ferr", int'(o_frame_err), 0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("ovr_pop%0d", i), int'(o_data), int'(ovr_bytes[i]));
            pop_one();
        end
        check_eq("ovr_drained", int'(o_valid), 0);
        clr_err();
        check_eq("ovr_cleared", int'(o_overrun), 0);

        // Glitch rejection.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("glitch_valid", int'(o_valid), 0);
        check_eq("glitch_ferr", int'(o_frame_err), 0);
        check_eq("glitch_ovr", int'(o_overrun), 0);
        send_frame(8'hC3, 1'b1, 1);
        check_eq("glitch_next", int'(o_data), 'hC3);
        pop_one();

        // Framing error with held-low line, flag left set for the reset test.
        send_frame(8'h7E, 1'b0, 3);
        check_eq("ferr_flag", int'(o_frame_err), 1);
        check_eq("ferr_nopush", int'(o_valid), 0);
        repeat (Cpb) @(negedge clk);
        send_frame(8'h42, 1'b1, 1);
        check_eq("ferr_next_valid", int'(o_valid), 1);
        check_eq("ferr_next_data", int'(o_data), 'h42);

        // Reset during data bit 4 with a byte still buffered.
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h99 >> i) & 1'b1;
            repeat (Cpb) @(negedge clk);
        end
        rx = 1'b1;
        repeat (Cpb / 2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("midrst_valid", int'(o_valid), 0);
        check_eq("midrst_data", int'(o_data), 0);
        check_eq("midrst_ferr", int'(o_frame_err), 0);
        check_eq("midrst_ovr", int'(o_overrun), 0);
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        send_and_time(8'h99, lat);
        check_eq("midrst_latency", lat, 991);
        check_eq("midrst_data99", int'(o_data), 'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
